// File: rtl/zigbee_cordic_rot.sv
// Rotation-mode pipelined CORDIC for the O-QPSK TX path: phase word in, constant-amplitude
// I/Q pair out, one sample per clock with a fixed latency of NUM_STAGES+3 cycles.
module zigbee_cordic_rot #(
  parameter int NUM_STAGES = 4,
  parameter int IQ_SIZE    = 5,
  parameter int W_SIZE     = 6,
  parameter int ANG_FRAC   = 4,
  parameter int AMP        = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W_SIZE-1:0]  win,
  input  logic               iValid,
  output logic [IQ_SIZE-1:0] ibb,
  output logic [IQ_SIZE-1:0] qbb,
  output logic               oValid
);

  localparam int XW  = IQ_SIZE + 2;
  localparam int ZW  = W_SIZE + ANG_FRAC + 1;
  localparam int ZB  = W_SIZE + ANG_FRAC;
  localparam int X0  = (AMP * 607253 + 500000) / 1000000;
  localparam int SAT = (1 << (IQ_SIZE - 1)) - 1;
  // atan(2^-i) for a full turn of 2^16, rescaled with rounding to the z resolution
  localparam int ATAN_65K [0:5] = '{8192, 4836, 2555, 1297, 651, 326};

  localparam logic signed [XW-1:0] X0_P   = XW'(X0);
  localparam logic signed [XW-1:0] X0_N   = XW'(-X0);
  localparam logic signed [XW-1:0] SAT_HI = XW'(SAT);
  localparam logic signed [XW-1:0] SAT_LO = XW'(-SAT);

  function automatic logic signed [ZW-1:0] atan_z(input int i);
    int v;
    v = (ATAN_65K[i] + (32'sd1 <<< (15 - ZB))) >>> (16 - ZB);
    return ZW'(v);
  endfunction

  // Shift that truncates toward zero, keeping the rotation odd-symmetric across quadrants
  function automatic logic signed [XW-1:0] shr_tz(input logic signed [XW-1:0] v, input int sh);
    logic signed [XW-1:0] bias;
    bias = v[XW-1] ? XW'((32'sd1 <<< sh) - 32'sd1) : {XW{1'b0}};
    return (v + bias) >>> sh;
  endfunction

  function automatic logic [IQ_SIZE-1:0] sat_iq(input logic signed [XW-1:0] v);
    logic [IQ_SIZE-1:0] r;
    if (v > SAT_HI) r = SAT_HI[IQ_SIZE-1:0];
    else if (v < SAT_LO) r = SAT_LO[IQ_SIZE-1:0];
    else r = v[IQ_SIZE-1:0];
    return r;
  endfunction

  logic [W_SIZE-1:0]     win_r;
  logic [NUM_STAGES+1:0] vld_r;
  logic signed [XW-1:0]  x_r    [0:NUM_STAGES];
  logic signed [XW-1:0]  y_r    [0:NUM_STAGES];
  logic signed [ZW-1:0]  z_r    [0:NUM_STAGES-1];
  logic signed [XW-1:0]  x_nx_s [0:NUM_STAGES-1];
  logic signed [XW-1:0]  y_nx_s [0:NUM_STAGES-1];
  logic signed [ZW-1:0]  z_nx_s [0:NUM_STAGES-1];
  logic signed [XW-1:0]  x0_s;
  logic signed [XW-1:0]  y0_s;
  logic signed [ZW-1:0]  z0_s;

  // Quadrant pre-rotation: start vector from the top two phase bits, residual from the rest
  always_comb begin
    x0_s = {XW{1'b0}};
    y0_s = {XW{1'b0}};
    z0_s = {3'b000, win_r[W_SIZE-3:0], {ANG_FRAC{1'b0}}};
    case (win_r[W_SIZE-1:W_SIZE-2])
      2'd0:    x0_s = X0_P;
      2'd1:    y0_s = X0_P;
      2'd2:    x0_s = X0_N;
      2'd3:    y0_s = X0_N;
      default: x0_s = X0_P;
    endcase
  end

  // Micro-rotation stages: rotate toward z = 0
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (z_r[i][ZW-1]) begin
        x_nx_s[i] = x_r[i] + shr_tz(y_r[i], i);
        y_nx_s[i] = y_r[i] - shr_tz(x_r[i], i);
        z_nx_s[i] = z_r[i] + atan_z(i);
      end else begin
        x_nx_s[i] = x_r[i] - shr_tz(y_r[i], i);
        y_nx_s[i] = y_r[i] + shr_tz(x_r[i], i);
        z_nx_s[i] = z_r[i] - atan_z(i);
      end
    end
  end

  // Pipeline, valid shift chain and saturating output register
  always_ff @(posedge clk) begin
    if (reset) begin
      win_r  <= {W_SIZE{1'b0}};
      vld_r  <= {(NUM_STAGES+2){1'b0}};
      for (int i = 0; i <= NUM_STAGES; i++) begin
        x_r[i] <= {XW{1'b0}};
        y_r[i] <= {XW{1'b0}};
      end
      for (int i = 0; i < NUM_STAGES; i++) begin
        z_r[i] <= {ZW{1'b0}};
      end
      ibb    <= {IQ_SIZE{1'b0}};
      qbb    <= {IQ_SIZE{1'b0}};
      oValid <= 1'b0;
    end else begin
      win_r  <= win;
      vld_r  <= {vld_r[NUM_STAGES:0], iValid};
      x_r[0] <= x0_s;
      y_r[0] <= y0_s;
      z_r[0] <= z0_s;
      for (int i = 0; i < NUM_STAGES; i++) begin
        x_r[i+1] <= x_nx_s[i];
        y_r[i+1] <= y_nx_s[i];
      end
      for (int i = 0; i < NUM_STAGES - 1; i++) begin
        z_r[i+1] <= z_nx_s[i];
      end
      oValid <= vld_r[NUM_STAGES+1];
      if (vld_r[NUM_STAGES+1]) begin
        ibb <= sat_iq(x_r[NUM_STAGES]);
        qbb <= sat_iq(y_r[NUM_STAGES]);
      end else begin
        ibb <= ibb;
        qbb <= qbb;
      end
    end
  end

endmodule
